pipe_stage_skid: RTL and testbench

- Parametrised pipeline stage register for the core's inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the fixed-field, stall-only latch with a valid/ready handshake, an optional skid entry for a registered ready, a synchronous flush that inserts a bubble, and a saturating stall-cycle counter for performance monitoring.
- Payload is split into data fields (held on bubble) and control fields (forced to zero on bubble, so a bubble can never write a register or memory).

---
 rtl/pipe_stage_skid.sv | 107 ++++++++++
 tb/tb_pipe_stage_skid.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and an optional skid entry.
// Control bits are zeroed on a bubble. A saturating counter tracks downstream stalls.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 9,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              skid_full_q, skid_full_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, drain;

    // With a skid, ready depends only on state, so ready_i has no path to ready_o.
    assign ready_o = (SKID != 0) ? ~skid_full_q : (ready_i | ~valid_q);
    assign accept  = valid_i & ready_o;
    assign drain   = valid_q & ready_i;

    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        ctrl_d      = ctrl_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        cnt_d       = cnt_q;

        if (!valid_q || drain) begin
            if (skid_full_q) begin
                valid_d     = 1'b1;
                data_d      = skid_data_q;
                ctrl_d      = skid_ctrl_q;
                skid_full_d = 1'b0;
                skid_ctrl_d = '0;
            end else if (accept) begin
                valid_d = 1'b1;
                data_d  = data_i;
                ctrl_d  = ctrl_i;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
        end else if (accept && (SKID != 0)) begin
            skid_full_d = 1'b1;
            skid_data_d = data_i;
            skid_ctrl_d = ctrl_i;
        end

        // Flush drops everything held but leaves data_o as it was.
        if (flush_i) begin
            valid_d     = 1'b0;
            data_d      = data_q;
            ctrl_d      = '0;
            skid_full_d = 1'b0;
            skid_data_d = skid_data_q;
            skid_ctrl_d = '0;
        end

        if (valid_q && !ready_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            ctrl_q      <= '0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign ctrl_o      = ctrl_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid and no-skid variants plus a narrow counter.
// All three instances share stimulus; each scenario checks the instances it targets.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 9;

    logic          clk = 1'b0;
    logic          start_i, flush_i, valid_i, ready_i;
    logic [DW-1:0] data_i;
    logic [CW-1:0] ctrl_i;

    logic          s_ready, s_valid, t_ready, t_valid, n_ready, n_valid;
    logic [DW-1:0] s_data, t_data, n_data;
    logic [CW-1:0] s_ctrl, t_ctrl, n_ctrl;
    logic [15:0]   s_cnt, n_cnt;
    logic [3:0]    t_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_skid (
        .clk_i(clk), .start_i(start_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(s_ready),
        .data_i(data_i), .ctrl_i(ctrl_i), .valid_o(s_valid), .ready_i(ready_i),
        .data_o(s_data), .ctrl_o(s_ctrl), .stall_cnt_o(s_cnt));

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_sat (
        .clk_i(clk), .start_i(start_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(t_ready),
        .data_i(data_i), .ctrl_i(ctrl_i), .valid_o(t_valid), .ready_i(ready_i),
        .data_o(t_data), .ctrl_o(t_ctrl), .stall_cnt_o(t_cnt));

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_ns (
        .clk_i(clk), .start_i(start_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(n_ready),
        .data_i(data_i), .ctrl_i(ctrl_i), .valid_o(n_valid), .ready_i(ready_i),
        .data_o(n_data), .ctrl_o(n_ctrl), .stall_cnt_o(n_cnt));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        data_i = '0; ctrl_i = '0;
        step();
        step();
        start_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
        checks++; if (s_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", s_data); end
        checks++; if (s_ctrl !== 9'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=000", s_ctrl); end
        checks++; if (s_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", s_cnt); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_skid got=%b exp=1", s_ready); end
        checks++; if (n_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_noskid got=%b exp=1", n_ready); end
    endtask

    task automatic test_stream();
        do_reset();
        ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            valid_i = 1'b1; data_i = DW'(i); ctrl_i = CW'(i);
            step();
            checks++; if (s_valid !== 1'b1 || s_data !== DW'(i))
                begin failures++; $display("FAIL stream_skid[%0d] got v=%b d=%h exp v=1 d=%h", i, s_valid, s_data, DW'(i)); end
            checks++; if (n_valid !== 1'b1 || n_data !== DW'(i))
                begin failures++; $display("FAIL stream_noskid[%0d] got v=%b d=%h exp v=1 d=%h", i, n_valid, n_data, DW'(i)); end
        end
        // Bubble drains the last entry.
        valid_i = 1'b0;
        step();
        checks++; if (s_valid !== 1'b0 || s_ctrl !== 9'h0 || s_data !== 16'h5)
            begin failures++; $display("FAIL bubble got v=%b c=%h d=%h exp v=0 c=000 d=0005", s_valid, s_ctrl, s_data); end
        checks++; if (s_cnt !== 16'd0) begin failures++; $display("FAIL stream_cnt got=%0d exp=0", s_cnt); end
    endtask

    task automatic test_skid_stall();
        do_reset();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 16'h10; ctrl_i = 9'h011;
        step();
        checks++; if (s_ready !== 1'b1 || s_data !== 16'h10)
            begin failures++; $display("FAIL stall_a got r=%b d=%h exp r=1 d=0010", s_ready, s_data); end
        data_i = 16'h20; ctrl_i = 9'h022;
        step();
        checks++; if (s_ready !== 1'b0 || s_data !== 16'h10)
            begin failures++; $display("FAIL stall_b got r=%b d=%h exp r=0 d=0010", s_ready, s_data); end
        checks++; if (n_ready !== 1'b0) begin failures++; $display("FAIL noskid_ready_stall got=%b exp=0", n_ready); end
        ready_i = 1'b1;
        #1;
        checks++; if (n_ready !== 1'b1) begin failures++; $display("FAIL noskid_ready_comb got=%b exp=1", n_ready); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL skid_ready_registered got=%b exp=0", s_ready); end
        ready_i = 1'b0;
        data_i = 16'h30; ctrl_i = 9'h033;
        step();
        step();
        checks++; if (s_cnt !== 16'd3 || s_data !== 16'h10 || s_ready !== 1'b0)
            begin failures++; $display("FAIL stall_hold got cnt=%0d d=%h r=%b exp cnt=3 d=0010 r=0", s_cnt, s_data, s_ready); end
        checks++; if (n_cnt !== 16'd3 || n_data !== 16'h10)
            begin failures++; $display("FAIL noskid_hold got cnt=%0d d=%h exp cnt=3 d=0010", n_cnt, n_data); end
        ready_i = 1'b1;
        step();
        checks++; if (s_valid !== 1'b1 || s_data !== 16'h20 || s_ctrl !== 9'h022 || s_ready !== 1'b1)
            begin failures++; $display("FAIL release_b got v=%b d=%h c=%h r=%b exp v=1 d=0020 c=022 r=1", s_valid, s_data, s_ctrl, s_ready); end
        // No skid: B was never accepted, C enters directly behind A.
        checks++; if (n_data !== 16'h30) begin failures++; $display("FAIL noskid_release got=%h exp=0030", n_data); end
        step();
        checks++; if (s_valid !== 1'b1 || s_data !== 16'h30 || s_ctrl !== 9'h033)
            begin failures++; $display("FAIL release_c got v=%b d=%h c=%h exp v=1 d=0030 c=033", s_valid, s_data, s_ctrl); end
        checks++; if (s_cnt !== 16'd3) begin failures++; $display("FAIL release_cnt got=%0d exp=3", s_cnt); end
        valid_i = 1'b0;
        step();
    endtask

    task automatic test_flush();
        do_reset();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 16'h10; ctrl_i = 9'h1FF;
        step();
        data_i = 16'h20;
        step();
        flush_i = 1'b1; data_i = 16'h40;
        step();
        flush_i = 1'b0;
        checks++; if (s_valid !== 1'b0 || s_ctrl !== 9'h0 || s_ready !== 1'b1 || s_data !== 16'h10)
            begin failures++; $display("FAIL flush got v=%b c=%h r=%b d=%h exp v=0 c=000 r=1 d=0010", s_valid, s_ctrl, s_ready, s_data); end
        checks++; if (s_cnt !== 16'd2) begin failures++; $display("FAIL flush_cnt got=%0d exp=2", s_cnt); end
        ready_i = 1'b1; data_i = 16'h50; ctrl_i = 9'h0A5;
        step();
        checks++; if (s_valid !== 1'b1 || s_data !== 16'h50 || s_ctrl !== 9'h0A5)
            begin failures++; $display("FAIL after_flush got v=%b d=%h c=%h exp v=1 d=0050 c=0A5", s_valid, s_data, s_ctrl); end
        // Entry offered during the flush edge must be discarded.
        flush_i = 1'b1; data_i = 16'h60;
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        checks++; if (s_valid !== 1'b0 || s_data !== 16'h50)
            begin failures++; $display("FAIL flush_accept got v=%b d=%h exp v=0 d=0050", s_valid, s_data); end
        step();
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL flush_no_dup got=%b exp=0", s_valid); end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 16'hAA; ctrl_i = 9'h155;
        step();
        data_i = 16'hBB;
        for (int i = 0; i < 20; i++) step();
        checks++; if (t_cnt !== 4'd15) begin failures++; $display("FAIL saturate got=%0d exp=15", t_cnt); end
        checks++; if (s_cnt !== 16'd20) begin failures++; $display("FAIL wide_cnt got=%0d exp=20", s_cnt); end
        start_i = 1'b0;
        step();
        start_i = 1'b1;
        checks++; if (t_cnt !== 4'd0 || t_valid !== 1'b0 || t_data !== 16'h0 || t_ctrl !== 9'h0 || t_ready !== 1'b1)
            begin failures++; $display("FAIL mid_reset got cnt=%0d v=%b d=%h c=%h r=%b exp 0 0 0000 000 1", t_cnt, t_valid, t_data, t_ctrl, t_ready); end
        ready_i = 1'b1; data_i = 16'h77; ctrl_i = 9'h007;
        step();
        checks++; if (t_valid !== 1'b1 || t_data !== 16'h77 || t_ctrl !== 9'h007)
            begin failures++; $display("FAIL post_reset got v=%b d=%h c=%h exp v=1 d=0077 c=007", t_valid, t_data, t_ctrl); end
        valid_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid_stall();
        test_flush();
        test_saturate_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
